// File: rtl/trunc_mul_pkg.sv
// trunc_mul_pkg: shared FSM state type and reference arithmetic for seq_trunc_mul.
// Build option: TRUNC_MUL_COMP_EN selects the compensation constant returned by comp_const.
package trunc_mul_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`ifdef TRUNC_MUL_COMP_EN
  localparam bit COMP_EN = 1'b1;
`else
  localparam bit COMP_EN = 1'b0;
`endif
  // Correction for the discarded low columns: half the weight of the truncated field.
  function automatic logic [63:0] comp_const(int n, int k);
    return (COMP_EN && k > 0 && k < n) ? 64'd1 << (2 * k - 1) : 64'd0;
  endfunction
  function automatic logic [63:0] trunc_ref(logic [63:0] a, logic [63:0] b, int n, int k);
    logic [63:0] msk;
    msk = (64'd1 << n) - 64'd1;
    return (((a & msk) >> k) * ((b & msk) >> k)) << (2 * k);
  endfunction
endpackage

// File: rtl/cska_acc.sv
// cska_acc: W-bit carry-skip adder, carry-in 0, skip blocks of BLK bits.
// Ports: x, y addends; s sum (carry-out dropped, the caller guarantees no overflow).
module cska_acc #(
  parameter int W   = 8,
  parameter int BLK = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] s
);
  logic c, c_blk, p_blk;
  // Ripple inside a block; when every bit of the block propagates, the block
  // carry-out is taken straight from the block carry-in.
  always_comb begin
    s = '0;
    c = 1'b0;
    c_blk = 1'b0;
    p_blk = 1'b1;
    for (int i = 0; i < W; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c = (x[i] & y[i]) | ((x[i] ^ y[i]) & c);
      p_blk = p_blk & (x[i] ^ y[i]);
      if (i % BLK == BLK - 1 || i == W - 1) begin
        c = p_blk ? c_blk : c;
        c_blk = c;
        p_blk = 1'b1;
      end
    end
  end
endmodule

// File: rtl/seq_trunc_mul.sv
// seq_trunc_mul: sequential truncated unsigned multiplier keeping partial products with i,j >= K.
// Ports: clk, rst_n (sync, active low); in_valid/in_ready/a/b operand handshake;
//        out_valid/out_ready/out result handshake (out is 2N bits, low 2K bits hold only C).
// Build option: TRUNC_MUL_COMP_EN adds the compensation constant to every result.
module seq_trunc_mul import trunc_mul_pkg::*; #(
  parameter int N          = 8,
  parameter int K          = 4,
  parameter int CSKA_BLOCK = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out
);
  localparam int M = N - K;
  localparam logic [M-1:0] LAST = M'(M - 1);
  localparam logic [2*N-1:0] C = (2*N)'(comp_const(N, K));
  if (N < 2 || N > 32 || K < 0 || K >= N || CSKA_BLOCK < 1) begin : g_bad_param
    $error("seq_trunc_mul: illegal N/K/CSKA_BLOCK");
  end
  if (K > 0) begin : g_lo
    logic unused_lo;
    assign unused_lo = ^{a[K-1:0], b[K-1:0]};
  end
  state_t state, state_n;
  logic [M-1:0] at, bt, cnt;
  logic [2*M-1:0] acc, addend, sum;
  assign addend = |(bt & (M'(1) << cnt)) ? (2*M)'(at) << cnt : '0;
  cska_acc #(.W(2 * M), .BLK(CSKA_BLOCK)) u_acc (.x(acc), .y(addend), .s(sum));
  assign out_valid = state == DONE;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && in_valid && in_ready) ? BUSY :
              (state == BUSY && cnt == LAST)          ? DONE :
              (state == DONE && out_ready)            ? IDLE : state;
  end
  // in_ready is registered so that it is low while reset is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b0;
      at <= '0;
      bt <= '0;
      cnt <= '0;
      acc <= '0;
      out <= '0;
    end else begin
      state <= state_n;
      in_ready <= state_n == IDLE;
      if (state == IDLE && in_valid && in_ready) begin
        at <= a[N-1:K];
        bt <= b[N-1:K];
        cnt <= '0;
        acc <= '0;
      end
      if (state == BUSY) begin
        acc <= sum;
        cnt <= cnt + M'(1);
        if (cnt == LAST) out <= ((2*N)'(sum) << (2 * K)) + C;
      end
    end
  end
  a_result: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> 64'(out) == trunc_ref(64'(at) << K, 64'(bt) << K, N, K) + comp_const(N, K));
  a_excl: assert property (@(posedge clk) disable iff (!rst_n) !(in_ready && out_valid));
endmodule

// File: tb/tb_seq_trunc_mul.sv
// tb_seq_trunc_mul: directed checks on an N=8,K=4 instance plus exhaustive N=6 sweeps for K=0..5.
module tb_seq_trunc_mul;
`ifdef TRUNC_MUL_COMP_EN
  localparam bit COMP = 1'b1;
`else
  localparam bit COMP = 1'b0;
`endif
  localparam logic [15:0] CM = COMP ? 16'h0080 : 16'h0000;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0, passed = 0, lanes_done = 0, cyc = 0;
  logic srst_n;

  function automatic longint model(int av, int bv, int n, int k);
    longint s;
    s = 0;
    for (int i = k; i < n; i++)
      for (int j = k; j < n; j++)
        if (av[i] && bv[j]) s += longint'(1) << (i + j);
    if (COMP && k > 0) s += longint'(1) << (2 * k - 1);
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  logic rst_n, in_valid, in_ready, out_valid, out_ready, prev_valid = 1'b0;
  logic [7:0] a, b;
  logic [15:0] out;
  typedef struct { logic [15:0] v; int c; } exp_t;
  exp_t mq[$];

  seq_trunc_mul #(.N(8), .K(4), .CSKA_BLOCK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out(out));

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) mq.delete();
    else if (in_valid && in_ready === 1'b1) mq.push_back('{16'(model(a, b, 8, 4)), cyc});
    else if (out_valid === 1'b1 && out_ready && mq.size() > 0) void'(mq.pop_front());
  end

  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1) begin
      check("main_pending", 64'(mq.size() > 0), 1);
      if (mq.size() > 0) begin
        check("main_out_model", 64'(out), 64'(mq[0].v));
        if (!prev_valid) check("main_latency_model", 64'(cyc - mq[0].c), 4);
      end
      check("main_ready_vs_valid", 64'(in_ready), 0);
    end
    prev_valid = out_valid === 1'b1;
  end

  task automatic issue(input logic [7:0] av, input logic [7:0] bv);
    int g;
    g = 0;
    in_valid = 1'b1; a = av; b = bv;
    while (in_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    check("issue_ready", 64'(g < 20), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
  endtask

  task automatic run(input string nm, input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp);
    int n;
    issue(av, bv);
    wait_valid(n);
    check({nm, "_out"}, 64'(out), 64'(exp));
    check({nm, "_lat"}, 64'(n), 4);
    @(negedge clk);
  endtask

  initial begin
    srst_n = 1'b0;
    repeat (2) @(negedge clk);
    srst_n = 1'b1;
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 0);
    check("reset_out_valid", 64'(out_valid), 0);
    check("reset_out", 64'(out), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_in_ready", 64'(in_ready), 1);
    run("ff_ff", 8'hFF, 8'hFF, 16'hE100 | CM);
    run("30_50", 8'h30, 8'h50, 16'h0F00 | CM);
    run("0f_ff", 8'h0F, 8'hFF, CM);
    out_ready = 1'b0;
    issue(8'hA5, 8'h3C);
    wait_valid(n);
    check("stall_lat", 64'(n), 4);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'h11; b = 8'h22;
      check("stall_out", 64'(out), 64'(16'h1E00 | CM));
      check("stall_valid", 64'(out_valid), 1);
      check("stall_in_ready", 64'(in_ready), 0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("release_valid_drop", 64'(out_valid), 0);
    check("release_out_kept", 64'(out), 64'(16'h1E00 | CM));
    @(negedge clk);
    issue(8'hFF, 8'hFF);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 0);
    check("midrst_out", 64'(out), 0);
    check("midrst_in_ready", 64'(in_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_release_ready", 64'(in_ready), 1);
    run("80_80", 8'h80, 8'h80, 16'h4000 | CM);
    for (int t = 0; t < 40000 && lanes_done < 6; t++) @(negedge clk);
    check("sweep_lanes_done", 64'(lanes_done), 6);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  for (genvar g = 0; g < 6; g++) begin : g_lane
    localparam int M = 6 - g;
    logic sv, srdy, sval;
    logic [5:0] sa, sb;
    logic [11:0] so;
    logic [11:0] eq[$];
    int ec[$];
    int lcyc = 0, prev = -1;

    seq_trunc_mul #(.N(6), .K(g), .CSKA_BLOCK(g % 3 + 1)) u_dut (
      .clk(clk), .rst_n(srst_n), .in_valid(sv), .in_ready(srdy), .a(sa), .b(sb),
      .out_valid(sval), .out_ready(1'b1), .out(so));

    always @(posedge clk) begin
      lcyc++;
      if (srst_n && sv && srdy === 1'b1) begin
        if (prev >= 0) check($sformatf("sweep_k%0d_interval", g), 64'(lcyc - prev), 64'(M + 2));
        prev = lcyc;
        eq.push_back(12'(model(sa, sb, 6, g)));
        ec.push_back(lcyc);
      end
    end

    always @(negedge clk) begin
      if (srst_n && sval === 1'b1) begin
        check($sformatf("sweep_k%0d_pending", g), 64'(eq.size() > 0), 1);
        if (eq.size() > 0) begin
          check($sformatf("sweep_k%0d_out_a%0h_b%0h", g, sa, sb), 64'(so), 64'(eq[0]));
          check($sformatf("sweep_k%0d_latency", g), 64'(lcyc - ec[0]), 64'(M));
          void'(eq.pop_front());
          void'(ec.pop_front());
        end
      end
    end

    initial begin
      int gd;
      sv = 1'b0; sa = '0; sb = '0;
      wait (srst_n === 1'b1);
      @(negedge clk);
      sv = 1'b1;
      for (int i = 0; i < 4096; i++) begin
        gd = 0;
        sa = 6'(i >> 6);
        sb = 6'(i);
        while (srdy !== 1'b1 && gd < 20) begin @(negedge clk); gd++; end
        check($sformatf("sweep_k%0d_ready", g), 64'(gd < 20), 1);
        @(negedge clk);
      end
      sv = 1'b0;
      for (int t = 0; t < 20 && eq.size() > 0; t++) @(negedge clk);
      check($sformatf("sweep_k%0d_drained", g), 64'(eq.size()), 0);
      lanes_done++;
    end
  end
endmodule

// File: doc/seq_trunc_mul.md
# seq_trunc_mul

Sequential, parametrised truncated unsigned multiplier with a valid/ready handshake on both sides. It keeps only the partial products a[i]&b[j] with i ≥ K and j ≥ K. It accumulates one kept row of b per clock through a carry-skip adder and returns a 2N-bit result whose low 2K bits are zero, or the compensation constant when that feature is compiled in. It is the area-reduced, multi-cycle successor to the fixed-width combinational truncated multipliers in the approximate-arithmetic library, for use inside datapaths that tolerate several cycles of latency.

## Interface
- N, default 8: operand width; legal range 2..32.
- K, default 4: truncation depth; legal range 0..N-1. N ≤ K is an elaboration error.
- CSKA_BLOCK, default 4: carry-skip block size of the accumulator adder; must be ≥ 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  N  multiplicand, unsigned.
- b  in  N  multiplier, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out  out  2N  truncated product.

## Operation
- Definitions: M = N-K; a_t = a[N-1:K]; b_t = b[N-1:K].
- Exact-truncated value: P = (a_t*b_t) << 2K. Bit-equivalent to the sum of all partial products with i,j ≥ K.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid&&in_ready: latch a_t and b_t, clear the M-bit row counter cnt and the 2M-bit accumulator acc, then go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle: acc ← acc + (b_t[cnt] ? (a_t << cnt) : 0), then cnt++.
  - When cnt == M-1, the update is performed and the FSM goes to DONE.
  - out is written on that same edge: (acc_final << 2K) + C.
- DONE:
  - out_valid = 1; out is held stable.
  - On out_ready: go to IDLE. out_valid drops and out keeps its last value.
  - If out_ready stays low, the FSM stays in DONE indefinitely and out/out_valid do not change.
- Inputs a/b/in_valid are ignored outside IDLE.
- Zero operands need no special handling: a_t=0 or b_t=0 gives acc=0, and the normal M-cycle latency still applies. There is no early termination.
- Width rule: acc is 2M bits wide and cannot overflow, since (2^M-1)^2 < 2^2M. The sum out = P + C < 2^2N for every legal K.

## Timing
- Reset values:
  - state = IDLE.
  - in_ready = 0 while rst_n = 0, 1 on the first cycle after release.
  - out_valid = 0, out = 0, acc = 0, cnt = 0.
- Reset mid-BUSY or mid-DONE:
  - The pending operation is discarded with no output.
  - The FSM returns to IDLE on the reset edge.
- Latency: with acceptance on edge E0, out_valid rises after edge E0+M (M BUSY cycles). For N=8, K=4 this is 4 cycles.
- Throughput:
  - Minimum issue interval is M+2 cycles, when out_ready is held high.
  - in_ready is never high in the same cycle as out_valid.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- TRUNC_MUL_COMP_EN defined:
  - C = 2^(2K-1) when K > 0, and C = 0 when K = 0.
  - C is a constant correction for the discarded columns and is added on the DONE write.
  - out[2K-1] may be 1.
- TRUNC_MUL_COMP_EN undefined:
  - C = 0.
  - out[2K-1:0] is always 0, and out equals P exactly.
- Latency and handshake are identical in both builds.

## Structure
- Package trunc_mul_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - the function comp_const(N, K) returning C;
  - the function trunc_ref(a, b, N, K) returning P, shared by RTL assertions and the testbench.
- Sub-module cska_acc: a parametrised 2M-bit carry-skip adder with block size CSKA_BLOCK that performs the accumulator add.
  - The carry-in is tied to 0.
  - Its skip logic uses per-block propagate AND.

## Test plan
- N=8, K=4, a=0xFF, b=0xFF, out_ready=1:
  - out=0xE100 (comp build 0xE180).
  - out_valid rises exactly 4 cycles after acceptance.
- N=8, K=4, a=0x30, b=0x50 → out=0x0F00.
- N=8, K=4, a=0x0F, b=0xFF → out=0x0000 (comp build 0x0080), with full 4-cycle latency.
- Backpressure: result held with out_ready=0 for 5 cycles.
  - out and out_valid stay stable and in_ready stays 0 throughout.
  - A new in_valid during the stall is not accepted.
- rst_n pulsed low during the second BUSY cycle:
  - Next cycle all outputs are 0 and in_ready=0 during reset.
  - After release, a fresh operation a=0x80, b=0x80 gives out=0x4000.
- Sweep: N=6, K=0..5, all 4096 operand pairs, back-to-back with out_ready=1.
  - Every out equals trunc_ref + comp_const.
  - Each issue interval equals M+2.
